// File: rtl/ifu_pkg.sv
// ============================================================================
// Module   : ifu_pkg
// Brief    : Shared widths, FSM encoding and FIFO entry layout for the
//            instruction fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifu_pkg;

    localparam int XLEN       = 32;
    localparam int INST_BYTES = 4;

    typedef enum logic [0:0] {
        IFU_RUN   = 1'b0,
        IFU_FLUSH = 1'b1
    } ifu_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/ifu_fifo.sv
// ============================================================================
// Module   : ifu_fifo
// Brief    : Generic registered synchronous FIFO with a single-cycle flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = pop && (r_count != '0);
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign w_push = push && ((r_count != c_cw'(DEPTH)) || w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            r_count <= r_count + c_cw'(w_push) - c_cw'(w_pop);
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/ifu_fetch.sv
// ============================================================================
// Module   : ifu_fetch
// Brief    : Instruction fetch unit: owns the fetch PC, issues credit-limited
//            word reads, buffers responses and flushes on redirect.
// Options  : IFU_PERF_EN adds perf_fetched / perf_flushed counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_req_ready,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed
`endif
);

    localparam int c_cw = $clog2(DEPTH) + 1;

    ifu_state_e      r_state;
    ifu_state_e      w_state_next;
    logic [XLEN-1:0] r_fetch_pc;
    logic [c_cw-1:0] r_stale;
    logic [c_cw-1:0] w_stale_next;
    logic [c_cw-1:0] w_outstanding;
    logic [c_cw-1:0] w_count;
    logic            w_credit;
    logic            w_req_fire;
    logic            w_rsp_accept;
    logic            w_pop;
    logic [XLEN-1:0] w_pcq_head;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head_entry;

    assign w_credit     = ((c_cw+1)'(w_count) + (c_cw+1)'(w_outstanding)) < (c_cw+1)'(DEPTH);
    assign w_req_fire   = mem_req_valid && mem_req_ready;
    assign w_rsp_accept = mem_rsp_valid && (r_state == IFU_RUN) && !redirect_valid;
    assign w_pop        = inst_valid && inst_ready && !redirect_valid;

    // In FLUSH nothing is outstanding and in RUN nothing is stale, so the sum
    // is always the number of responses still owed by memory.
    always_comb begin
        w_stale_next = r_stale;
        if (redirect_valid) begin
            w_stale_next = w_outstanding + r_stale - c_cw'(mem_rsp_valid);
        end else if ((r_state == IFU_FLUSH) && mem_rsp_valid) begin
            w_stale_next = r_stale - c_cw'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IFU_RUN;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (redirect_valid) begin
            w_state_next = (w_stale_next != '0) ? IFU_FLUSH : IFU_RUN;
        end else if ((r_state == IFU_FLUSH) && (w_stale_next == '0)) begin
            w_state_next = IFU_RUN;
        end
    end

    // rst gates the request so nothing is offered while the block is held in reset.
    always_comb begin
        mem_req_valid = rst && (r_state == IFU_RUN) && w_credit && !redirect_valid;
        mem_req_addr  = r_fetch_pc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_stale    <= '0;
        end else begin
            r_stale <= w_stale_next;
            if (redirect_valid)  r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            else if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(INST_BYTES);
        end
    end

    ifu_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (w_req_fire),
        .push_data (r_fetch_pc),
        .pop       (w_rsp_accept),
        .head      (w_pcq_head),
        .count     (w_outstanding)
    );

    assign w_push_entry = '{pc: w_pcq_head, inst: mem_rsp_data};

    ifu_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_data_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (w_rsp_accept),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head      (w_head_entry),
        .count     (w_count)
    );

    assign inst_valid = (w_count != '0);
    assign inst       = w_head_entry.inst;
    assign inst_pc    = w_head_entry.pc;

`ifdef IFU_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_flushed;
    logic        w_rsp_drop;

    assign w_rsp_drop = mem_rsp_valid && (redirect_valid || (r_state == IFU_FLUSH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_fetched <= '0;
            r_perf_flushed <= '0;
        end else begin
            if (w_pop) r_perf_fetched <= r_perf_fetched + 32'd1;
            r_perf_flushed <= r_perf_flushed
                            + (redirect_valid ? 32'(w_count) : 32'd0)
                            + 32'(w_rsp_drop);
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_flushed = r_perf_flushed;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// ============================================================================
// Module   : tb_ifu_fetch
// Brief    : Self-checking bench for ifu_fetch with a fixed-latency memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    // second instance only checks address wrap from the top of memory
    logic        wr_zero = 1'b0;
    logic        wr_one  = 1'b1;
    logic [31:0] wr_zero32 = 32'h0;
    logic        wr_req_valid;
    logic [31:0] wr_req_addr;
    logic        wr_inst_valid;
    logic [31:0] wr_inst;
    logic [31:0] wr_inst_pc;

`ifdef IFU_PERF_EN
    logic [31:0] perf_fetched, perf_flushed, wr_perf_fetched, wr_perf_flushed;
`endif

    always #5 clk = ~clk;

    ifu_fetch #(.RESET_PC(32'h8000_0000), .DEPTH(2)) u_dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
`ifdef IFU_PERF_EN
        , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
    );

    ifu_fetch #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) u_wrap (
        .clk(clk), .rst(rst),
        .redirect_valid(wr_zero), .redirect_pc(wr_zero32),
        .mem_req_valid(wr_req_valid), .mem_req_addr(wr_req_addr), .mem_req_ready(wr_one),
        .mem_rsp_valid(wr_zero), .mem_rsp_data(wr_zero32),
        .inst_valid(wr_inst_valid), .inst(wr_inst), .inst_pc(wr_inst_pc), .inst_ready(wr_zero)
`ifdef IFU_PERF_EN
        , .perf_fetched(wr_perf_fetched), .perf_flushed(wr_perf_flushed)
`endif
    );

    // ---------------- memory model: in-order, fixed latency ----------------
    int unsigned cyc = 0;
    int unsigned lat = 1;
    logic [31:0] q_addr[$];
    int unsigned q_due[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mem_rsp_valid && q_addr.size() > 0) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        if (mem_req_valid && mem_req_ready) begin
            q_addr.push_back(mem_req_addr);
            q_due.push_back(cyc + lat - 1);
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drive(input logic rdy, input logic irdy, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = word_of(q_addr[0]);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 32'h0;
        end
        mem_req_ready  = rdy;
        inst_ready     = irdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic assert_reset(input int unsigned l);
        rst            = 1'b0;
        lat            = l;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mem_req_ready  = 1'b1;
        inst_ready     = 1'b0;
        q_addr.delete();
        q_due.delete();
    endtask

    task automatic release_reset();
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic wait_inst(input string name, input logic [31:0] exp_pc);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            if (inst_valid) begin
                seen = 1'b1;
                chk({name, " first inst_pc"}, inst_pc, exp_pc);
                chk({name, " first inst"}, inst, word_of(exp_pc));
            end
        end
        chk({name, " inst_valid seen within bound"}, 32'(seen), 32'd1);
    endtask

    typedef struct {
        logic        irdy;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vt[11];

    initial begin
        // startup with L=1 then backpressure; DEPTH=2 credit limits issue
        vt[0]  = '{1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 1'b1, 32'h8000_0004, 1'b0, 32'h0};
        vt[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0000};
        vt[3]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0000};
        vt[4]  = '{1'b0, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0004};
        vt[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0004};
        vt[6]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0004};
        vt[7]  = '{1'b1, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0008};
        vt[8]  = '{1'b1, 1'b1, 32'h8000_0010, 1'b0, 32'h0};
        vt[9]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_000C};
        vt[10] = '{1'b1, 1'b1, 32'h8000_0014, 1'b1, 32'h8000_0010};

        // ---- reset state ----
        assert_reset(1);
        repeat (2) @(posedge clk);
        #1;
        chk("reset mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("reset inst_valid", 32'(inst_valid), 32'd0);
        chk("reset mem_req_addr", mem_req_addr, 32'h8000_0000);
        chk("reset inst", inst, 32'h0);
        chk("reset inst_pc", inst_pc, 32'h0);
        release_reset();

        // ---- table-driven startup / backpressure ----
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, vt[i].irdy, 1'b0, 32'h0);
            chk($sformatf("v%0d mem_req_valid", i), 32'(mem_req_valid), 32'(vt[i].exp_rv));
            if (vt[i].exp_rv)
                chk($sformatf("v%0d mem_req_addr", i), mem_req_addr, vt[i].exp_addr);
            chk($sformatf("v%0d inst_valid", i), 32'(inst_valid), 32'(vt[i].exp_iv));
            if (vt[i].exp_iv) begin
                chk($sformatf("v%0d inst_pc", i), inst_pc, vt[i].exp_pc);
                chk($sformatf("v%0d inst", i), inst, word_of(vt[i].exp_pc));
            end
            if (i == 0) begin
                chk("wrap first addr", wr_req_addr, 32'hFFFF_FFFC);
                chk("wrap first valid", 32'(wr_req_valid), 32'd1);
            end
            if (i == 1) chk("wrap second addr", wr_req_addr, 32'h0000_0000);
        end

        // ---- async reset mid-run while an instruction is presented ----
        #1 rst = 1'b0;
        #1;
        chk("async reset run inst_valid", 32'(inst_valid), 32'd0);
        chk("async reset run mem_req_valid", 32'(mem_req_valid), 32'd0);
        assert_reset(3);
        release_reset();

        // ---- redirect with two in flight, L=3 ----
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        chk("redir c0 addr", mem_req_addr, 32'h8000_0000);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        chk("redir c1 addr", mem_req_addr, 32'h8000_0004);
        drive(1'b1, 1'b0, 1'b1, 32'h8000_0103);
        chk("redir c2 req withdrawn", 32'(mem_req_valid), 32'd0);
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            chk($sformatf("flush c%0d stale rsp", k), 32'(mem_rsp_valid), 32'd1);
            chk($sformatf("flush c%0d mem_req_valid", k), 32'(mem_req_valid), 32'd0);
            chk($sformatf("flush c%0d inst_valid", k), 32'(inst_valid), 32'd0);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        chk("after flush mem_req_valid", 32'(mem_req_valid), 32'd1);
        chk("after flush mem_req_addr", mem_req_addr, 32'h8000_0100);
        wait_inst("redirect L3", 32'h8000_0100);

        // ---- redirect coinciding with a response, L=1 ----
        assert_reset(1);
        release_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        chk("redir+rsp c0 addr", mem_req_addr, 32'h8000_0000);
        drive(1'b1, 1'b0, 1'b1, 32'h8000_0200);
        chk("redir+rsp c1 req withdrawn", 32'(mem_req_valid), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        chk("redir+rsp c2 mem_req_valid", 32'(mem_req_valid), 32'd1);
        chk("redir+rsp c2 mem_req_addr", mem_req_addr, 32'h8000_0200);
        chk("redir+rsp c2 inst_valid", 32'(inst_valid), 32'd0);
        wait_inst("redirect+rsp", 32'h8000_0200);

        // ---- async reset while in FLUSH ----
        assert_reset(3);
        release_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 32'h8000_0300);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        #1 rst = 1'b0;
        #1;
        chk("async reset flush mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("async reset flush inst_valid", 32'(inst_valid), 32'd0);
        chk("async reset flush fetch addr", mem_req_addr, 32'h8000_0000);
`ifdef IFU_PERF_EN
        chk("async reset perf_fetched", perf_fetched, 32'd0);
        chk("async reset perf_flushed", perf_flushed, 32'd0);
`endif
        assert_reset(1);
        release_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        chk("post reset mem_req_valid", 32'(mem_req_valid), 32'd1);
        chk("post reset mem_req_addr", mem_req_addr, 32'h8000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit sitting directly upstream of the single-cycle core datapath. It owns the architectural fetch PC and issues word reads to instruction memory over a valid/ready request channel. It buffers in-order responses in a small prefetch FIFO and presents `{inst, inst_pc}` to the decode stage with a valid/ready handshake. A redirect from execute (branch/jump) flushes the buffered and in-flight instructions and restarts fetch at the new PC.

## Interface
- `RESET_PC`, default 32'h80000000: fetch PC loaded on reset.
- `DEPTH`, default 2: prefetch FIFO entries; also the cap on requests in flight plus entries buffered. Must be a power of two, ≥2.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `redirect_valid`  in  1  execute requests a fetch restart this cycle.
- `redirect_pc`  in  32  restart address; bits [1:0] are forced to 0 internally.
- `mem_req_valid`  out  1  read request present.
- `mem_req_addr`  out  32  word-aligned read address.
- `mem_req_ready`  in  1  memory accepts the request this cycle.
- `mem_rsp_valid`  in  1  read data returned, in request order, exactly one per accepted request.
- `mem_rsp_data`  in  32  instruction word.
- `inst_valid`  out  1  FIFO head valid.
- `inst`  out  32  instruction at FIFO head.
- `inst_pc`  out  32  PC of `inst`.
- `inst_ready`  in  1  decode consumes the head this cycle.

## Operation
- **State**
  - `fetch_pc` (32b)
  - `outstanding` count (0..DEPTH)
  - `stale` count (0..DEPTH)
  - FIFO of `{pc, inst}` with `count` (0..DEPTH)
  - FSM with two states, RUN and FLUSH.
- **Credit rule:** a request may issue only when `count + outstanding < DEPTH`.
- **RUN**
  - `mem_req_valid = credit && !redirect_valid`.
  - `mem_req_addr = fetch_pc`.
  - On accept (valid && ready): `fetch_pc += 4` (mod 2^32, 32'hFFFFFFFC wraps to 0) and `outstanding++`.
  - On `mem_rsp_valid`: push `{pc_of_oldest_outstanding, mem_rsp_data}` and `outstanding--`. The PC of each in-flight request is tracked in a DEPTH-entry PC queue alongside the data FIFO.
- **Pop:** `inst_valid && inst_ready` removes the head.
- **Redirect in any state** (redirect_valid=1):
  - FIFO cleared and `fetch_pc <= {redirect_pc[31:2],2'b0}`.
  - A response arriving in the same cycle is discarded.
  - `stale <= outstanding - mem_rsp_valid`, and `outstanding` is cleared.
  - Next state is FLUSH if that `stale` value is ≠0, else RUN.
  - Any un-accepted request is withdrawn that cycle; the memory must tolerate withdrawal on redirect.
- **FLUSH**
  - `mem_req_valid=0`.
  - Each `mem_rsp_valid` is dropped and decrements `stale`.
  - When `stale` reaches 0, go to RUN on the next edge.
- **Simultaneous events**
  - Push and pop in the same cycle both take effect; `count` is unchanged.
  - Redirect overrides push and pop.
  - A redirect in FLUSH reloads `stale` with the same rule, counting remaining stale responses only.
- **Reset** (asynchronous, including mid-operation):
  - State → RUN; `fetch_pc=RESET_PC`; all counts 0.
  - `inst_valid=0`, `mem_req_valid=0` while `rst=0`.
  - `inst`/`inst_pc` reset to 0; `mem_req_addr=RESET_PC`.
  - Responses to requests issued before reset are the memory's responsibility; memory is reset together with this block.

## Timing
- `mem_req_valid` and `mem_req_addr` are combinational from registered state and `redirect_valid` only; no path from `mem_req_ready`.
- Response→`inst_valid` latency: 1 cycle (registered FIFO, no bypass).
- Request accepted at cycle t with memory latency L≥1 → `inst_valid` at t+L+1.
- A pop frees a credit from the next cycle; no same-cycle credit reuse.
- First request is issued in the first cycle after `rst` deasserts.
- Steady-state throughput is 1 instr/cycle with L=1 and DEPTH≥2.

## Configuration
- `IFU_PERF_EN`
  - Defined: adds outputs `perf_fetched` (32b, increments on each pop) and `perf_flushed` (32b, increments per FIFO entry cleared plus per stale response dropped). Both reset to 0 and wrap.
  - Undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- **Shared package `ifu_pkg`**
  - `XLEN=32`, `INST_BYTES=4`.
  - FSM enum `ifu_state_e {IFU_RUN, IFU_FLUSH}`.
  - Packed struct `fetch_entry_t {pc, inst}`.
- **Sub-module `ifu_fifo`:** a generic synchronous FIFO parameterised on width/depth, with a `flush` input. Instantiated twice: the PC-tracking queue and the output data queue.

## Test plan
- **Reset:** hold `rst=0` 3 cycles, release; memory ready=1 with L=1 → `mem_req_addr` 0x80000000, 0x80000004, …. First `inst_valid` two cycles after release, with `inst_pc`=0x80000000.
- **Backpressure:** `inst_ready=0`, DEPTH=2 → exactly 2 requests issue, then `mem_req_valid=0`. With `inst_ready=1` for one cycle, one new request issues the following cycle.
- **Redirect with 2 in flight:** L=3, redirect to 0x80000103 → next request address 0x80000100 issues only after 2 stale responses are dropped. No stale word ever appears on `inst`.
- **Redirect + response same cycle:** response is discarded, `stale`=outstanding−1, and the first valid `inst_pc` is the redirect target.
- **Wrap:** RESET_PC=32'hFFFFFFFC → addresses 0xFFFFFFFC then 0x00000000.
- **Async reset mid-FLUSH:** assert `rst` asynchronously → `inst_valid` and `mem_req_valid` drop before the next edge. With `IFU_PERF_EN`, counters read 0.
